// File: rtl/mem_copy.sv
// Byte-wide forward memory copy engine: one read and one write per cycle,
// refusing any copy whose destination window would touch the status/bank register.
module mem_copy #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] readaddr,
  input  logic [DATA_W-1:0] readdata,
  output logic [ADDR_W-1:0] writeaddr,
  output logic [DATA_W-1:0] writedata,
  output logic              write_en
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    COPY   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PROT_ADDR = ADDR_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              err_q;
  logic              zdone_q;
  logic              accept_c;
  logic              hits_prot_c;
  logic              last_c;

  // Protected address lies in the window iff its wrapped offset from dst is below length.
  always_comb begin
    hits_prot_c = ADDR_W'(PROT_ADDR - dst_addr) < length;
    accept_c    = (state == IDLE) && start;
    last_c      = cnt_q == ADDR_W'(len_q - ADDR_W'(1));
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start && (length != '0) && !hits_prot_c) begin
          state_nxt = FIRST;
        end
      end
      FIRST:  state_nxt = COPY;
      COPY: begin
        if (last_c) begin
          state_nxt = FINISH;
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Captured parameters, byte counter and the IDLE-side status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      zdone_q <= 1'b0;
    end else begin
      err_q   <= accept_c && hits_prot_c;
      zdone_q <= accept_c && (length == '0);
      if (accept_c) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
        len_q <= length;
      end
      if (state == COPY) begin
        cnt_q <= cnt_q + ADDR_W'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // Output decode; read runs one address ahead of write so data arrives just in time
  always_comb begin
    busy      = 1'b0;
    done      = zdone_q;
    err       = err_q;
    readaddr  = '0;
    writeaddr = '0;
    writedata = '0;
    write_en  = 1'b0;
    unique case (state)
      IDLE: begin
      end
      FIRST: begin
        busy     = 1'b1;
        readaddr = src_q;
      end
      COPY: begin
        busy      = 1'b1;
        readaddr  = src_q + cnt_q + ADDR_W'(1);
        writeaddr = dst_q + cnt_q;
        writedata = readdata;
        write_en  = 1'b1;
      end
      FINISH: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy.sv
// Bench for mem_copy: write-first byte memory, table-driven and random copies
// checked against a sequential forward-copy reference model.
module tb_mem_copy;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] src_addr, dst_addr, length;
  logic       busy, done, err;
  logic [7:0] readaddr, readdata, writeaddr, writedata;
  logic       write_en;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic       pl_we;
  logic [7:0] pl_addr, pl_data;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    string      name;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    bit         inj;
    bit         exp_err;
  } vec_t;

  vec_t vt [10];

  mem_copy #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .readaddr  (readaddr),
    .readdata  (readdata),
    .writeaddr (writeaddr),
    .writedata (writedata),
    .write_en  (write_en)
  );

  always #5 clk = ~clk;

  // Write-first synchronous memory with a bench-side preload port
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (write_en) mem[writeaddr] <= writedata;
    readdata <= (write_en && writeaddr == readaddr) ? writedata : mem[readaddr];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: reject if 0x01 is in the wrapped window, else copy byte by byte in order
  function automatic bit model_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    logic [7:0] off;
    off = 8'h01 - d;
    if (off < l) return 1'b1;
    for (int k = 0; k < int'(l); k++) begin
      ref_mem[8'(d + 8'(k))] = ref_mem[8'(s + 8'(k))];
    end
    return 1'b0;
  endfunction

  task automatic cmp_mem(input string nm);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk({nm, " mem"}, 32'(bad), 32'd0);
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = v;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic run_copy(input string nm, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input bit inj, output bit saw_err);
    int  nbusy, ndone, nerrp, nwr, done_at, err_at;
    bit  m_err;
    m_err = model_copy(s, d, l);
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; length = l;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0; ndone = 0; nerrp = 0; nwr = 0; done_at = -1; err_at = -1;
    for (int c = 0; c < int'(l) + 6; c++) begin
      if (busy) nbusy++;
      if (done) begin ndone++; done_at = c; end
      if (err) begin nerrp++; err_at = c; end
      if (write_en) nwr++;
      if (inj && c == 1) begin
        start = 1'b1; src_addr = 8'h00; dst_addr = 8'h90; length = 8'h09;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    saw_err = (nerrp > 0);
    chk({nm, " err_pulses"}, 32'(nerrp), m_err ? 32'd1 : 32'd0);
    chk({nm, " err_at"}, 32'(err_at), m_err ? 32'd0 : 32'hFFFF_FFFF);
    chk({nm, " done_pulses"}, 32'(ndone), m_err ? 32'd0 : 32'd1);
    if (!m_err) chk({nm, " done_at"}, 32'(done_at), (l == 8'd0) ? 32'd0 : 32'(int'(l) + 1));
    chk({nm, " busy_cycles"}, 32'(nbusy), (m_err || l == 8'd0) ? 32'd0 : 32'(int'(l) + 2));
    chk({nm, " writes"}, 32'(nwr), m_err ? 32'd0 : 32'(l));
    cmp_mem(nm);
  endtask

  initial begin
    bit         e;
    logic [7:0] reg01;
    logic [7:0] v;

    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;

    vt[0] = '{"basic",      8'h10, 8'h20, 8'd4,   1'b0, 1'b0};
    vt[1] = '{"wrap_src",   8'hFE, 8'h40, 8'd3,   1'b0, 1'b0};
    vt[2] = '{"prot_dst0",  8'h60, 8'h00, 8'd2,   1'b0, 1'b1};
    vt[3] = '{"overlap_up", 8'h30, 8'h31, 8'd3,   1'b0, 1'b0};
    vt[4] = '{"zero_len",   8'h50, 8'h01, 8'd0,   1'b0, 1'b0};
    vt[5] = '{"busy_start", 8'h70, 8'h78, 8'd4,   1'b1, 1'b0};
    vt[6] = '{"prot_dst1",  8'h50, 8'h01, 8'd1,   1'b0, 1'b1};
    vt[7] = '{"prot_wrapd", 8'h50, 8'hFF, 8'd3,   1'b0, 1'b1};
    vt[8] = '{"overlap_dn", 8'h84, 8'h82, 8'd5,   1'b0, 1'b0};
    vt[9] = '{"full_win",   8'h03, 8'h02, 8'd255, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst write_en", 32'(write_en), 32'd0);
    chk("rst readaddr", 32'(readaddr), 32'd0);
    chk("rst writeaddr", 32'(writeaddr), 32'd0);
    chk("rst writedata", 32'(writedata), 32'd0);

    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      if (i >= 8'h10 && i <= 8'h13) v = 8'(i - 8'h0F);
      if (i == 8'h30) v = 8'hAA;
      ref_mem[i] = v;
      poke(8'(i), v);
    end
    reg01 = ref_mem[1];
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_copy(vt[i].name, vt[i].src, vt[i].dst, vt[i].len, vt[i].inj, e);
      chk({vt[i].name, " table_err"}, 32'(e), 32'(vt[i].exp_err));
      if (i == 0) for (int j = 0; j < 4; j++) chk("basic byte", 32'(mem[8'h20 + j]), 32'(j + 1));
      if (i == 3) for (int j = 1; j < 4; j++) chk("overlap byte", 32'(mem[8'h30 + j]), 32'hAA);
    end
    chk("reg01 kept", 32'(mem[1]), 32'(reg01));

    // Reset during COPY k=1 of a 4-byte copy: only the first byte lands
    e = model_copy(8'hA0, 8'hB0, 8'd1);
    @(negedge clk);
    start = 1'b1; src_addr = 8'hA0; dst_addr = 8'hB0; length = 8'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst we_before", 32'(write_en), 32'd1);
    chk("midrst waddr_before", 32'(writeaddr), 32'hB1);
    reset = 1'b1;
    #1;
    chk("midrst write_en", 32'(write_en), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst readaddr", 32'(readaddr), 32'd0);
    chk("midrst writeaddr", 32'(writeaddr), 32'd0);
    chk("midrst writedata", 32'(writedata), 32'd0);
    repeat (3) @(negedge clk);
    cmp_mem("midrst");

    // Start presented with reset release is taken on the very next edge
    e = model_copy(8'hC0, 8'hC8, 8'd2);
    reset = 1'b0;
    start = 1'b1; src_addr = 8'hC0; dst_addr = 8'hC8; length = 8'd2;
    @(negedge clk);
    start = 1'b0;
    chk("postrst busy", 32'(busy), 32'd1);
    repeat (6) @(negedge clk);
    chk("postrst idle", 32'(busy), 32'd0);
    cmp_mem("postrst");

    for (int i = 0; i < 24; i++) begin
      run_copy("rand", 8'($urandom), 8'($urandom), 8'($urandom_range(0, 24)), 1'b0, e);
    end
    chk("reg01 final", 32'(mem[1]), 32'(reg01));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/mem_copy.md
MEM_COPY -- requirements
Module: mem_copy

Interface
REQ-001 Parameters SHALL be: ADDR_W, 8, address width; DATA_W, 8, data width.
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle request pulse, sampled only in IDLE.
REQ-005 src_addr  in  ADDR_W  first source address, captured with start.
REQ-006 dst_addr  in  ADDR_W  first destination address, captured with start.
REQ-007 length  in  ADDR_W  byte count, captured with start; 0 = no-op.
REQ-008 busy  out  1  high from the cycle after an accepted start until done/err.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 err  out  1  one-cycle rejection pulse.
REQ-011 readaddr  out  ADDR_W  read address to the memory controller.
REQ-012 readdata  in  DATA_W  memory read data, valid one cycle after readaddr is presented.
REQ-013 writeaddr  out  ADDR_W  write address to the memory controller.
REQ-014 writedata  out  DATA_W  write data.
REQ-015 write_en  out  1  write strobe; memory commits on the rising edge while high.

Function
REQ-016 The FSM SHALL have the states IDLE, FIRST, COPY and FINISH.
- IDLE->FIRST on start with length!=0 and no error.
- FIRST->COPY after one cycle.
- COPY->FINISH after the last write.
- FINISH->IDLE after one cycle.
REQ-017 FIRST SHALL drive readaddr=src with write_en=0.
REQ-018 In COPY cycle k (k=0..length-1), the block SHALL drive:
- writeaddr=dst+k, writedata=readdata, write_en=1;
- readaddr=src+k+1 concurrently.
REQ-019 Throughput SHALL be one byte per cycle; busy SHALL be high for exactly length+2 cycles (FIRST + length COPY cycles + FINISH).
REQ-020 done SHALL pulse for the single cycle in which FINISH is left.
REQ-021 Address arithmetic SHALL be modulo 2^ADDR_W; 0xFF+1 wraps to 0x00 with no error.
REQ-022 The status/bank register at address 0x01 SHALL never be written by the engine.
- If the destination window dst..dst+length-1 (modulo wrap) contains 0x01, the block SHALL assert err for one cycle from IDLE.
- In that case there SHALL be no busy, no writes and no done.
REQ-023 length=0 SHALL produce a done pulse one cycle after start, with busy and write_en never asserted.
REQ-024 start SHALL be ignored while busy; the captured parameters SHALL be unaffected.
REQ-025 Overlapping regions SHALL follow sequential forward-copy semantics (byte k is read after byte k-1 is written, given a write-first memory).
- dst=src+1 SHALL replicate mem[src] across the window.
- dst<src SHALL give an exact copy.
REQ-026 write_en SHALL be low in IDLE, FIRST and FINISH.
REQ-027 The engine SHALL NOT alter the memory bank select; copies occur within the current bank.

Reset
REQ-028 reset SHALL immediately (asynchronously) force:
- state=IDLE;
- busy=0, done=0, err=0, write_en=0;
- readaddr=0, writeaddr=0, writedata=0.
REQ-029 Reset asserted mid-copy SHALL abort the copy; writes already committed SHALL remain, and no further write SHALL occur.
REQ-030 After reset deassertion, the first start SHALL be accepted on the next rising edge.

Verification
REQ-031 Basic copy: mem[0x10..0x13]={1,2,3,4}; start src=0x10 dst=0x20 len=4 -> mem[0x20..0x23]={1,2,3,4}, busy for 6 cycles, one done pulse.
REQ-032 Wrap: src=0xFE dst=0x40 len=3 -> mem[0x40..0x42]=mem[0xFE],mem[0xFF],mem[0x00]; no err.
REQ-033 Protected register: dst=0x00 len=2 -> err pulse one cycle after start, write_en never high, mem[0x01] unchanged.
REQ-034 Overlap: mem[0x30]=0xAA; src=0x30 dst=0x31 len=3 -> mem[0x31..0x33]=0xAA.
REQ-035 Zero length and busy-start: len=0 -> done after 1 cycle with no write; second start during a len=4 copy -> ignored, exactly 4 writes.
REQ-036 Reset mid-copy: assert reset in COPY cycle k=1 of a len=4 copy -> write_en drops at once, only dst+0 written, dst+1..dst+3 unchanged.
